// File: rtl/countdown_timer.sv
// countdown_timer: BCD countdown 59.99..00.00 in hundredths with alarm; TIMER_RELOAD_EN selects auto-reload
module countdown_timer #(
   parameter int FREQ = 50000000
) (
   input  logic       ck,
   input  logic       cl_n,
   input  logic       ld,
   input  logic [3:0] p0,
   input  logic [3:0] p1,
   input  logic [3:0] p2,
   input  logic [3:0] p3,
   input  logic       start,
   input  logic       stop,
   input  logic       ack,
   output logic [3:0] c0,
   output logic [3:0] c1,
   output logic [3:0] s0,
   output logic [3:0] s1,
   output logic       running,
   output logic       alarm
);
   localparam int FDIV = FREQ / 100;
   localparam int PW = (FDIV > 1) ? $clog2(FDIV) : 1;
   localparam logic [PW-1:0] PLOAD = PW'(FDIV - 1);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   state_t        state_q;
   logic [15:0]   cnt_q, pre_q, ld_d, dec_d;
   logic [PW-1:0] psc_q;
   logic          alarm_q, b0, b1, b2, dec_zero;
   function automatic logic [3:0] sat(input logic [3:0] v, input logic [3:0] m);
      return (v > m) ? m : v;
   endfunction
   assign ld_d = {sat(p3, 4'd5), sat(p2, 4'd9), sat(p1, 4'd9), sat(p0, 4'd9)};
   assign {s1, s0, c1, c0} = cnt_q;
   assign running = (state_q == RUN);
   assign alarm = alarm_q;
   // BCD borrow chain: each digit borrows only when all lower digits are zero
   always_comb begin
      b0 = (cnt_q[3:0] == 4'd0);
      b1 = b0 && (cnt_q[7:4] == 4'd0);
      b2 = b1 && (cnt_q[11:8] == 4'd0);
      dec_d[3:0]   = b0 ? 4'd9 : cnt_q[3:0] - 4'd1;
      dec_d[7:4]   = b1 ? 4'd9 : b0 ? cnt_q[7:4] - 4'd1 : cnt_q[7:4];
      dec_d[11:8]  = b2 ? 4'd9 : b1 ? cnt_q[11:8] - 4'd1 : cnt_q[11:8];
      dec_d[15:12] = b2 ? cnt_q[15:12] - 4'd1 : cnt_q[15:12];
      dec_zero     = (dec_d == 16'h0000);
   end
   // control FSM, prescaler, count and alarm; alarm defaults to "state is DONE" and is overridden per event
   always_ff @(posedge ck) begin
      if (!cl_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pre_q   <= '0;
         psc_q   <= '0;
         alarm_q <= 1'b0;
      end else begin
         alarm_q <= (state_q == DONE);
         if (ld) begin
            pre_q   <= ld_d;
            cnt_q   <= ld_d;
            state_q <= IDLE;
            alarm_q <= 1'b0;
         end else if (ack && state_q == DONE) begin
            cnt_q   <= pre_q;
            state_q <= IDLE;
            alarm_q <= 1'b0;
         end else if (stop && state_q == RUN) begin
            state_q <= PAUSE;
         end else if (start && state_q == IDLE) begin
            psc_q   <= PLOAD;
            state_q <= (cnt_q == 16'h0000) ? DONE : RUN;
            alarm_q <= (cnt_q == 16'h0000);
         end else if (start && state_q == PAUSE) begin
            state_q <= RUN;
         end else if (state_q == RUN) begin
            if (psc_q == '0) begin
               psc_q   <= PLOAD;
               alarm_q <= dec_zero;
`ifdef TIMER_RELOAD_EN
               cnt_q   <= dec_zero ? pre_q : dec_d;
`else
               cnt_q   <= dec_d;
               if (dec_zero) state_q <= DONE;
`endif
            end else begin
               psc_q <= psc_q - PW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed self-checking bench for countdown_timer at FREQ=400 (tick every 4 cycles)
module tb_countdown_timer;
`ifdef TIMER_RELOAD_EN
   localparam bit RL = 1'b1;
`else
   localparam bit RL = 1'b0;
`endif
   logic       ck = 1'b0, cl_n = 1'b0, ld = 1'b0, start = 1'b0, stop = 1'b0, ack = 1'b0;
   logic [3:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;
   logic [3:0] c0, c1, s0, s1;
   logic       running, alarm;
   logic [15:0] cnt;
   int n_cmp = 0, n_bad = 0;
   assign cnt = {s1, s0, c1, c0};
   countdown_timer #(.FREQ(400)) dut (
      .ck(ck), .cl_n(cl_n), .ld(ld), .p0(p0), .p1(p1), .p2(p2), .p3(p3),
      .start(start), .stop(stop), .ack(ack),
      .c0(c0), .c1(c1), .s0(s0), .s1(s1), .running(running), .alarm(alarm)
   );
   always #5 ck = ~ck;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge ck);
   endtask
   task automatic ldp(input logic [15:0] p);
      {p3, p2, p1, p0} = p;
      ld = 1'b1;
      @(negedge ck);
      ld = 1'b0;
   endtask
   task automatic go();
      start = 1'b1;
      @(negedge ck);
      start = 1'b0;
   endtask
   initial begin
      cyc(1);
      chk("rst_cnt", cnt, 16'h0000);
      chk("rst_run", running, 0);
      chk("rst_alarm", alarm, 0);
      cl_n = 1'b1;
      ldp(16'h0003);
      chk("ld3_cnt", cnt, 16'h0003);
      chk("ld3_run", running, 0);
      go();
      chk("go3_run", running, 1);
      cyc(3);
      chk("pre_tick", cnt, 16'h0003);
      cyc(1);
      chk("tick1", cnt, 16'h0002);
      cyc(4);
      chk("tick2", cnt, 16'h0001);
      cyc(3);
      chk("pre_zero_alarm", alarm, 0);
      cyc(1);
      chk("zero_cnt", cnt, RL ? 16'h0003 : 16'h0000);
      chk("zero_alarm", alarm, 1);
      chk("zero_run", running, RL ? 1 : 0);
      cyc(1);
      chk("after_zero_alarm", alarm, RL ? 0 : 1);
      go();
      chk("done_start_ign", cnt, RL ? 16'h0003 : 16'h0000);
      ldp(16'h0100);
      go();
      cyc(4);
      chk("borrow_0100", cnt, 16'h0099);
      ldp(16'h1000);
      go();
      cyc(4);
      chk("borrow_1000", cnt, 16'h0999);
      ldp(16'h0005);
      go();
      cyc(4);
      chk("p_tick1", cnt, 16'h0004);
      cyc(2);
      stop = 1'b1;
      @(negedge ck);
      stop = 1'b0;
      chk("pause_run", running, 0);
      cyc(5);
      chk("pause_hold", cnt, 16'h0004);
      go();
      chk("resume_run", running, 1);
      cyc(1);
      chk("resume_1", cnt, 16'h0004);
      cyc(1);
      chk("resume_tick", cnt, 16'h0003);
      cyc(3);
      stop = 1'b1;
      @(negedge ck);
      stop = 1'b0;
      chk("stop_on_tick", cnt, 16'h0003);
      chk("stop_on_tick_run", running, 0);
      go();
      cyc(1);
      chk("after_stop_tick", cnt, 16'h0002);
      ack = 1'b1;
      @(negedge ck);
      ack = 1'b0;
      chk("ack_in_run", running, 1);
      ldp(16'h7CAF);
      chk("saturate", cnt, 16'h5999);
      {p3, p2, p1, p0} = 16'h0002;
      ld = 1'b1;
      start = 1'b1;
      @(negedge ck);
      ld = 1'b0;
      start = 1'b0;
      chk("ld_start_run", running, 0);
      cyc(4);
      chk("ld_start_cnt", cnt, 16'h0002);
      ldp(16'h0000);
      go();
      chk("zero_go_alarm", alarm, 1);
      chk("zero_go_run", running, 0);
      ack = 1'b1;
      @(negedge ck);
      ack = 1'b0;
      chk("zero_ack_alarm", alarm, 0);
      ldp(16'h0002);
      go();
      cyc(4);
      chk("t6_tick1", cnt, 16'h0001);
      cyc(4);
      chk("t6_zero_cnt", cnt, RL ? 16'h0002 : 16'h0000);
      chk("t6_zero_alarm", alarm, 1);
      chk("t6_zero_run", running, RL ? 1 : 0);
      cyc(1);
      chk("t6_pulse_end", alarm, RL ? 0 : 1);
      ack = 1'b1;
      @(negedge ck);
      ack = 1'b0;
      chk("t6_ack_cnt", cnt, 16'h0002);
      chk("t6_ack_run", running, RL ? 1 : 0);
      chk("t6_ack_alarm", alarm, 0);
      ldp(16'h0042);
      go();
      cyc(2);
      cl_n = 1'b0;
      @(negedge ck);
      cl_n = 1'b1;
      chk("midrst_cnt", cnt, 16'h0000);
      chk("midrst_run", running, 0);
      go();
      chk("midrst_go_alarm", alarm, 1);
      ack = 1'b1;
      @(negedge ck);
      ack = 1'b0;
      chk("preset_lost", cnt, 16'h0000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
